mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Pipeline MEM stage; sits directly downstream of the execute stage and consumes its EX/MEM register outputs.
- Performs word loads and stores through a req/gnt/rvalid data-memory port, and stalls the pipeline while an access is outstanding.
- Aborts an access on timeout or misalignment.
- Owns the MEM/WB pipeline register feeding writeback.

Parameters:
- DATA_WIDTH, 32, data and address width.
- TIMEOUT, 16, max cycles waiting for gnt or rvalid before abort (≥2).
- CNT_WIDTH, 5, width of wait counter; must hold TIMEOUT.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- RegWriteM  in  1  register write enable from EX/MEM.
- ResultSrcM  in  1  1 = load (writeback selects ReadData).
- MemwriteM  in  1  store.
- ALUresultM  in  DATA_WIDTH  effective address / ALU result.
- WriteDataM  in  DATA_WIDTH  store data.
- PCplus4M  in  DATA_WIDTH  PC+4.
- RdM  in  5  destination register.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  DATA_WIDTH  word address, bits[1:0] = 0.
- dmem_wdata  out  DATA_WIDTH  store data.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  DATA_WIDTH  load data.
- StallM  out  1  to hazard unit; freezes F/D/E and EX/MEM while 1.
- mem_err  out  1  one-cycle pulse on misalign or timeout.
- RegWriteW, ResultSrcW  out  1 each  MEM/WB control.
- ReadDataW, ALUresultW, PCplus4W  out  DATA_WIDTH each  MEM/WB data.
- RdW  out  5  MEM/WB destination.

Behaviour:
- Access definition: access = MemwriteM | ResultSrcM.
  - misalign = access & (ALUresultM[1:0] != 0).
  - MemwriteM & ResultSrcM together is illegal; treat it as a store.
- States: IDLE, WAIT_GNT, WAIT_RSP.
  - Wait counter clears on entry to WAIT_GNT or WAIT_RSP and increments each cycle in those states.
- Request generation:
  - dmem_req = (IDLE & access & !misalign) | WAIT_GNT.
  - dmem_req is forced 0 while rst = 1.
  - dmem_we = MemwriteM.
  - dmem_addr = {ALUresultM[31:2], 2'b00}.
  - dmem_wdata = WriteDataM.
  - All request outputs are combinational from the held M inputs.
- IDLE transitions:
  - No access: pass-through, StallM = 0.
  - misalign: no request, mem_err = 1, StallM = 0, retire with RegWriteW = 0.
  - req & gnt, store: complete this cycle, stay IDLE.
  - req & gnt, load: go to WAIT_RSP.
  - req & !gnt: go to WAIT_GNT.
- WAIT_GNT transitions:
  - gnt, store: complete, go IDLE.
  - gnt, load: go WAIT_RSP.
- WAIT_RSP:
  - rvalid: capture dmem_rdata into ReadDataW, complete, go IDLE.
  - rvalid never coincides with the gnt cycle; rvalid outside WAIT_RSP is ignored.
- Timeout:
  - If the counter reaches TIMEOUT-1 in WAIT_GNT or WAIT_RSP without completion, abort.
  - Abort: mem_err = 1, dmem_req drops next cycle, StallM = 0, retire with RegWriteW = 0, ReadDataW = 0, go IDLE.
  - A late rvalid after abort is ignored.
- StallM:
  - StallM = 1 when (IDLE & access & !misalign & !(gnt & store)), or in WAIT_GNT/WAIT_RSP without completion or abort.
  - Upstream holds all M inputs stable while StallM = 1.
- MEM/WB register:
  - Updates every clock.
  - While StallM = 1, it loads a bubble: RegWriteW = 0, ResultSrcW = 0, other fields 0.
  - Otherwise it captures RegWriteM (masked to 0 on err), ResultSrcM, ALUresultM, PCplus4M, RdM, and ReadDataW (rdata on load completion, else 0).
- Latency:
  - Non-memory op and zero-wait store: 1 cycle, W valid next edge.
  - Load: at least 2 cycles (gnt, then rvalid).
- Reset:
  - All W outputs 0, state IDLE, counter 0, mem_err 0.
  - Reset mid-access abandons the access without mem_err.
  - Memory responses arriving after reset are ignored.

Test Plan:
- ALU op (RegWriteM = 1, RdM = 5, ALUresultM = 0x1234) -> next edge RegWriteW = 1, RdW = 5, ALUresultW = 0x1234; StallM and dmem_req stay 0.
- Store addr 0x100, data 0xDEADBEEF, gnt same cycle -> dmem_req = 1, dmem_we = 1, dmem_addr = 0x100; StallM = 0; no bubble.
- Load addr 0x204: gnt after 2 cycles, rvalid 3 cycles later with rdata = 0xCAFEF00D.
  - StallM = 1 for 5 cycles with bubbles in W.
  - Then ReadDataW = 0xCAFEF00D, ResultSrcW = 1, RegWriteW = 1.
- Load addr 0x202 -> no dmem_req, mem_err pulse, RegWriteW = 0, StallM = 0.
- Load with gnt but no rvalid -> abort after TIMEOUT = 16 cycles: mem_err = 1, RegWriteW = 0, ReadDataW = 0; a later rvalid is ignored.
- rst = 1 asserted in WAIT_RSP -> next edge: all outputs 0, IDLE, dmem_req = 0; a subsequent rvalid does not update ReadDataW.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage
//
// Pipeline MEM stage. It sits directly after the EX/MEM register and performs
// word loads and stores over a req/gnt/rvalid data-memory port. The rest of
// the pipeline is stalled while an access is outstanding. An access is
// aborted on a misaligned address or when the memory stays silent for too long.
// This module also owns the MEM/WB pipeline register that feeds writeback.
//
// Ports:
//   clk, rst                     clock (rising edge); synchronous active-high reset
//   RegWriteM, ResultSrcM,       EX/MEM control: register write enable, load
//   MemwriteM                    select (1 = load), store
//   ALUresultM, WriteDataM,      EX/MEM data: effective address / ALU result,
//   PCplus4M, RdM                store data, PC+4, destination register
//   dmem_req, dmem_we,           data-memory request channel, driven
//   dmem_addr, dmem_wdata        combinationally from the held M inputs
//   dmem_gnt, dmem_rvalid,       data-memory grant and read response
//   dmem_rdata
//   StallM                       freezes F/D/E and EX/MEM while high
//   mem_err                      one-cycle pulse on misalign or timeout
//   RegWriteW, ResultSrcW,       MEM/WB pipeline register
//   ReadDataW, ALUresultW,
//   PCplus4W, RdW
module mem_access_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteM,
    input  logic                  ResultSrcM,
    input  logic                  MemwriteM,
    input  logic [DATA_WIDTH-1:0] ALUresultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic [DATA_WIDTH-1:0] PCplus4M,
    input  logic [4:0]            RdM,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  StallM,
    output logic                  mem_err,
    output logic                  RegWriteW,
    output logic                  ResultSrcW,
    output logic [DATA_WIDTH-1:0] ReadDataW,
    output logic [DATA_WIDTH-1:0] ALUresultW,
    output logic [DATA_WIDTH-1:0] PCplus4W,
    output logic [4:0]            RdW
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RSP
    } stateT;

    stateT                 state;
    stateT                 stateNext;
    logic [CNT_WIDTH-1:0]  waitCnt;

    logic                  isAccess;
    logic                  isStore;
    logic                  misalign;
    logic                  timeoutHit;
    logic                  reqRaw;
    logic                  stallRaw;
    logic                  errRaw;
    logic                  rspCapture;

    // Decode the held M inputs. A combined store+load is illegal and is
    // treated as a store, so "store" is simply MemwriteM.
    assign isAccess   = MemwriteM | ResultSrcM;
    assign isStore    = MemwriteM;
    assign misalign   = isAccess & (ALUresultM[1:0] != 2'b00);
    assign timeoutHit = (waitCnt == CNT_WIDTH'(TIMEOUT - 1));

    // Request fields are pure pass-through of the held M inputs.
    assign dmem_we    = MemwriteM;
    assign dmem_addr  = {ALUresultM[DATA_WIDTH-1:2], 2'b00};
    assign dmem_wdata = WriteDataM;

    // Reset silences the request, stall and error outputs, so an access in
    // flight is abandoned quietly.
    assign dmem_req   = reqRaw & ~rst;
    assign StallM     = stallRaw & ~rst;
    assign mem_err    = errRaw & ~rst;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Wait counter: cleared whenever a wait state is entered (including
    // WAIT_GNT -> WAIT_RSP), then counts each cycle spent waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            waitCnt <= '0;
        end else if (stateNext != state) begin
            waitCnt <= '0;
        end else if (state != IDLE) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end

    // Next state and handshake outputs. A grant for a load in WAIT_GNT counts
    // as progress and moves on to WAIT_RSP instead of timing out. rvalid is
    // only honoured in WAIT_RSP.
    always_comb begin
        stateNext  = state;
        reqRaw     = 1'b0;
        stallRaw   = 1'b0;
        errRaw     = 1'b0;
        rspCapture = 1'b0;
        case (state)
            IDLE: begin
                if (misalign) begin
                    errRaw = 1'b1;
                end else if (isAccess) begin
                    reqRaw = 1'b1;
                    if (!dmem_gnt) begin
                        stateNext = WAIT_GNT;
                        stallRaw  = 1'b1;
                    end else if (!isStore) begin
                        stateNext = WAIT_RSP;
                        stallRaw  = 1'b1;
                    end
                end
            end
            WAIT_GNT: begin
                reqRaw = 1'b1;
                if (dmem_gnt) begin
                    if (isStore) begin
                        stateNext = IDLE;
                    end else begin
                        stateNext = WAIT_RSP;
                        stallRaw  = 1'b1;
                    end
                end else if (timeoutHit) begin
                    errRaw    = 1'b1;
                    stateNext = IDLE;
                end else begin
                    stallRaw = 1'b1;
                end
            end
            WAIT_RSP: begin
                if (dmem_rvalid) begin
                    rspCapture = 1'b1;
                    stateNext  = IDLE;
                end else if (timeoutHit) begin
                    errRaw    = 1'b1;
                    stateNext = IDLE;
                end else begin
                    stallRaw = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // MEM/WB register. A bubble is inserted while stalled; an erroring
    // instruction still retires but with its register write suppressed.
    always_ff @(posedge clk) begin
        if (rst || StallM) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
            ReadDataW  <= '0;
            ALUresultW <= '0;
            PCplus4W   <= '0;
            RdW        <= '0;
        end else begin
            RegWriteW  <= RegWriteM & ~mem_err;
            ResultSrcW <= ResultSrcM;
            ReadDataW  <= rspCapture ? dmem_rdata : '0;
            ALUresultW <= ALUresultM;
            PCplus4W   <= PCplus4M;
            RdW        <= RdM;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
//
// Directed bench for mem_access_stage. A transaction-level model follows
// the access (busy / granted / cycles waited) and predicts the request,
// stall and error outputs, plus the next MEM/WB contents. These predictions
// are compared with the DUT on every falling edge. Scenario code adds
// hand-computed literal checks on top of the model comparisons.
module tb_mem_access_stage;

    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk;
    logic          rst;
    logic          RegWriteM;
    logic          ResultSrcM;
    logic          MemwriteM;
    logic [DW-1:0] ALUresultM;
    logic [DW-1:0] WriteDataM;
    logic [DW-1:0] PCplus4M;
    logic [4:0]    RdM;
    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_gnt;
    logic          dmem_rvalid;
    logic [DW-1:0] dmem_rdata;
    logic          StallM;
    logic          mem_err;
    logic          RegWriteW;
    logic          ResultSrcW;
    logic [DW-1:0] ReadDataW;
    logic [DW-1:0] ALUresultW;
    logic [DW-1:0] PCplus4W;
    logic [4:0]    RdW;

    int total = 0;
    int bad   = 0;

    mem_access_stage #(
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO),
        .CNT_WIDTH (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .MemwriteM  (MemwriteM),
        .ALUresultM (ALUresultM),
        .WriteDataM (WriteDataM),
        .PCplus4M   (PCplus4M),
        .RdM        (RdM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_gnt   (dmem_gnt),
        .dmem_rvalid(dmem_rvalid),
        .dmem_rdata (dmem_rdata),
        .StallM     (StallM),
        .mem_err    (mem_err),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .ReadDataW  (ReadDataW),
        .ALUresultW (ALUresultW),
        .PCplus4W   (PCplus4W),
        .RdW        (RdW)
    );

    // Free-running clock, first rising edge at t=5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something stalls the scenario sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rw, input logic rs, input logic mw,
                                 input logic [31:0] alu, input logic [31:0] wd,
                                 input logic [31:0] pc4, input logic [4:0] rd);
        RegWriteM  = rw;
        ResultSrcM = rs;
        MemwriteM  = mw;
        ALUresultM = alu;
        WriteDataM = wd;
        PCplus4M   = pc4;
        RdM        = rd;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Plays the memory side of one access: gnt on cycle gntAt, rvalid with
    // data on cycle rvAt (-1 = never). Returns in the first non-stalled cycle.
    task automatic runAccess(input int gntAt, input int rvAt, input logic [31:0] data,
                             output int stalls, output logic sawErr);
        stalls = 0;
        sawErr = 1'b0;
        for (int c = 0; c < 64; c++) begin
            dmem_gnt    = (c == gntAt);
            dmem_rvalid = (c == rvAt);
            dmem_rdata  = (c == rvAt) ? data : 32'h13579BDF;
            #1;
            if (mem_err === 1'b1) sawErr = 1'b1;
            if (StallM !== 1'b1) return;
            stalls++;
            @(posedge clk);
            #1;
        end
        total++;
        bad++;
        $display("[TB] FAIL accessBound: still stalled after 64 cycles, expected release");
    endtask

    // Transaction-level reference state.
    bit            mBusy    = 1'b0;
    bit            mGranted = 1'b0;
    int            mWaited  = 0;
    logic          expRegWrite  = 1'b0;
    logic          expResultSrc = 1'b0;
    logic [31:0]   expRead = 32'h0;
    logic [31:0]   expAlu  = 32'h0;
    logic [31:0]   expPc   = 32'h0;
    logic [4:0]    expRd   = 5'd0;

    // Compare process: W outputs against the prediction from the previous
    // cycle, request/stall/error against this cycle's prediction, then
    // advance the model using the inputs the next rising edge will see.
    always @(negedge clk) begin
        bit access, store, mis, req, stall, err, done, gotData, progress;
        checkOutput("RegWriteW",  RegWriteW,  expRegWrite);
        checkOutput("ResultSrcW", ResultSrcW, expResultSrc);
        checkOutput("ReadDataW",  ReadDataW,  expRead);
        checkOutput("ALUresultW", ALUresultW, expAlu);
        checkOutput("PCplus4W",   PCplus4W,   expPc);
        checkOutput("RdW",        RdW,        expRd);

        access  = (MemwriteM === 1'b1) || (ResultSrcM === 1'b1);
        store   = (MemwriteM === 1'b1);
        mis     = access && (ALUresultM % 4 != 0);
        req     = 1'b0;
        stall   = 1'b0;
        err     = 1'b0;
        gotData = 1'b0;
        if (rst) begin
            mBusy = 1'b0;
        end else if (!mBusy) begin
            req   = access && !mis;
            err   = mis;
            stall = req && !(dmem_gnt && store);
            if (stall) begin
                mBusy    = 1'b1;
                mGranted = dmem_gnt;
                mWaited  = 0;
            end
        end else begin
            req      = !mGranted;
            done     = mGranted ? dmem_rvalid : (dmem_gnt && store);
            progress = !mGranted && dmem_gnt;
            gotData  = mGranted && dmem_rvalid;
            err      = !done && !progress && (mWaited == TO - 1);
            stall    = !done && !err;
            if (!stall) begin
                mBusy = 1'b0;
            end else if (progress) begin
                mGranted = 1'b1;
                mWaited  = 0;
            end else begin
                mWaited++;
            end
        end

        checkOutput("dmem_req",   dmem_req,   req);
        checkOutput("StallM",     StallM,     stall);
        checkOutput("mem_err",    mem_err,    err);
        checkOutput("dmem_we",    dmem_we,    MemwriteM);
        checkOutput("dmem_addr",  dmem_addr,  ALUresultM & 32'hFFFF_FFFC);
        checkOutput("dmem_wdata", dmem_wdata, WriteDataM);

        if (rst || stall) begin
            expRegWrite  = 1'b0;
            expResultSrc = 1'b0;
            expRead      = 32'h0;
            expAlu       = 32'h0;
            expPc        = 32'h0;
            expRd        = 5'd0;
        end else begin
            expRegWrite  = RegWriteM && !err;
            expResultSrc = ResultSrcM;
            expRead      = gotData ? dmem_rdata : 32'h0;
            expAlu       = ALUresultM;
            expPc        = PCplus4M;
            expRd        = RdM;
        end
    end

    // Directed scenarios with literal expectations.
    initial begin
        int   stalls;
        logic sawErr;
        rst = 1'b1;
        applyIdle();

        // Reset state.
        repeat (2) nextCycle();
        checkOutput("resetRegWriteW", RegWriteW, 1'b0);
        checkOutput("resetReadDataW", ReadDataW, 32'h0);
        checkOutput("resetDmemReq",   dmem_req,  1'b0);
        checkOutput("resetMemErr",    mem_err,   1'b0);
        rst = 1'b0;
        nextCycle();

        // Plain ALU op passes straight through.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 32'h104, 5'd5);
        #1;
        checkOutput("aluStall", StallM,   1'b0);
        checkOutput("aluReq",   dmem_req, 1'b0);
        nextCycle();
        applyIdle();
        #1;
        checkOutput("aluRegWriteW",  RegWriteW,  1'b1);
        checkOutput("aluRdW",        RdW,        5'd5);
        checkOutput("aluALUresultW", ALUresultW, 32'h1234);

        // Zero-wait store.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 32'h108, 5'd0);
        dmem_gnt = 1'b1;
        #1;
        checkOutput("storeReq",   dmem_req,   1'b1);
        checkOutput("storeWe",    dmem_we,    1'b1);
        checkOutput("storeAddr",  dmem_addr,  32'h100);
        checkOutput("storeWdata", dmem_wdata, 32'hDEADBEEF);
        checkOutput("storeStall", StallM,     1'b0);
        nextCycle();
        applyIdle();
        #1;
        checkOutput("storeALUresultW", ALUresultW, 32'h100);
        checkOutput("storePCplus4W",   PCplus4W,   32'h108);

        // Load: gnt on cycle 2, rvalid on cycle 5.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h204, 32'h0, 32'h10C, 5'd7);
        runAccess(2, 5, 32'hCAFEF00D, stalls, sawErr);
        checkOutput("loadStallCycles", stalls, 5);
        nextCycle();
        applyIdle();
        #1;
        checkOutput("loadReadDataW",  ReadDataW,  32'hCAFEF00D);
        checkOutput("loadResultSrcW", ResultSrcW, 1'b1);
        checkOutput("loadRegWriteW",  RegWriteW,  1'b1);
        checkOutput("loadRdW",        RdW,        5'd7);

        // Misaligned load.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h202, 32'h0, 32'h110, 5'd8);
        #1;
        checkOutput("misReq",   dmem_req, 1'b0);
        checkOutput("misErr",   mem_err,  1'b1);
        checkOutput("misStall", StallM,   1'b0);
        nextCycle();
        applyIdle();
        #1;
        checkOutput("misRegWriteW",  RegWriteW,  1'b0);
        checkOutput("misALUresultW", ALUresultW, 32'h202);

        // Load granted at once, never answered: abort after TIMEOUT cycles.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 32'h114, 5'd9);
        runAccess(0, -1, 32'h0, stalls, sawErr);
        checkOutput("timeoutStallCycles", stalls, 16);
        checkOutput("timeoutErr",         sawErr, 1'b1);
        nextCycle();
        applyIdle();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h55555555;
        #1;
        checkOutput("abortRegWriteW", RegWriteW, 1'b0);
        checkOutput("abortReadDataW", ReadDataW, 32'h0);
        checkOutput("abortReq",       dmem_req,  1'b0);
        nextCycle();
        dmem_rvalid = 1'b0;
        #1;
        checkOutput("lateRvalidReadDataW", ReadDataW, 32'h0);

        // Store that waits three cycles for its grant.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 32'h118, 5'd0);
        runAccess(3, -1, 32'h0, stalls, sawErr);
        checkOutput("waitStoreStalls", stalls, 3);
        nextCycle();
        applyIdle();
        #1;
        checkOutput("waitStoreALUresultW", ALUresultW, 32'h400);

        // Reset while a load waits for its response.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 32'h11C, 5'd10);
        dmem_gnt = 1'b1;
        #1;
        checkOutput("rstLoadStall0", StallM, 1'b1);
        nextCycle();
        dmem_gnt = 1'b0;
        #1;
        checkOutput("rstLoadStall1", StallM, 1'b1);
        nextCycle();
        rst = 1'b1;
        applyIdle();
        nextCycle();
        checkOutput("rstRegWriteW",  RegWriteW,  1'b0);
        checkOutput("rstALUresultW", ALUresultW, 32'h0);
        checkOutput("rstPCplus4W",   PCplus4W,   32'h0);
        checkOutput("rstReq",        dmem_req,   1'b0);
        rst         = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h77777777;
        nextCycle();
        dmem_rvalid = 1'b0;
        #1;
        checkOutput("postRstReadDataW", ReadDataW, 32'h0);
        checkOutput("postRstStall",     StallM,    1'b0);

        repeat (2) nextCycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
